// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Read-side consumer for the 8-bit TX FIFO. It pops one byte at a time and
// serializes it as an asynchronous UART frame on o_txd: a start bit, 8 data
// bits LSB first, an optional even-parity bit, then STOP_BITS stop bits.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit follows data bit 7
//   undefined -> data bit 7 is followed directly by the stop bit(s)
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (4..65535)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_enable       allows new frames to start; a running frame always completes
//   i_fifo_empty   FIFO empty flag, sampled only in IDLE
//   i_fifo_dout    FIFO read data, sampled only in LOAD
//   o_fifo_rd_en   registered single-cycle pop request
//   o_txd          serial line, idles high
//   o_busy         high whenever the FSM is not in IDLE
//   o_tx_done      one-cycle pulse after the last stop-bit period
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line high, waiting for ENABLE and a non-empty FIFO
// FETCH   | pop request asserted towards the FIFO
// LOAD    | FIFO data now valid; latch it and drive the start bit
// START   | start bit (low) on the line
// DATA    | data bits 0..7, LSB first
// PARITY  | even-parity bit (only with UART_TX_PARITY_EN)
// STOP    | stop bit(s), line high

module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_fifo_empty,
   input  logic [7:0] i_fifo_dout,
   output logic       o_fifo_rd_en,
   output logic       o_txd,
   output logic       o_busy,
   output logic       o_tx_done
);

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_t;

   state_t      r_state;
   logic [15:0] r_baud_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic        r_txd;
   logic        r_rd_en;
   logic        r_tx_done;

   state_t      w_state_nxt;
   logic [15:0] w_baud_nxt;
   logic [2:0]  w_bit_nxt;
   logic [7:0]  w_shift_nxt;
   logic        w_txd_nxt;
   logic        w_rd_en_nxt;
   logic        w_tx_done_nxt;
   logic        w_baud_tc;

`ifdef UART_TX_PARITY_EN
   // Parity is captured with the byte because the shift register is
   // consumed while the data bits go out.
   logic r_parity;
   logic w_parity_nxt;
`endif

   assign w_baud_tc = (r_baud_cnt == BAUD_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_txd      <= 1'b1;
         r_rd_en    <= 1'b0;
         r_tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_txd      <= w_txd_nxt;
         r_rd_en    <= w_rd_en_nxt;
         r_tx_done  <= w_tx_done_nxt;
`ifdef UART_TX_PARITY_EN
         r_parity   <= w_parity_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud_cnt;
      w_bit_nxt     = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_txd_nxt     = r_txd;
      w_rd_en_nxt   = 1'b0;
      w_tx_done_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt  = r_parity;
`endif

      case (r_state)
         ST_IDLE: begin
            w_txd_nxt = 1'b1;
            if (i_enable && !i_fifo_empty) begin
               w_state_nxt = ST_FETCH;
               w_rd_en_nxt = 1'b1;
            end
         end

         ST_FETCH: begin
            w_state_nxt = ST_LOAD;
         end

         ST_LOAD: begin
            w_shift_nxt  = i_fifo_dout;
            w_txd_nxt    = 1'b0;
            w_baud_nxt   = '0;
            w_state_nxt  = ST_START;
`ifdef UART_TX_PARITY_EN
            w_parity_nxt = ^i_fifo_dout;
`endif
         end

         ST_START: begin
            if (w_baud_tc) begin
               w_baud_nxt  = '0;
               w_txd_nxt   = r_shift[0];
               w_bit_nxt   = '0;
               w_state_nxt = ST_DATA;
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end

         ST_DATA: begin
            if (w_baud_tc) begin
               w_baud_nxt = '0;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_txd_nxt   = r_parity;
                  w_state_nxt = ST_PARITY;
`else
                  w_txd_nxt   = 1'b1;
                  w_bit_nxt   = '0;
                  w_state_nxt = ST_STOP;
`endif
               end else begin
                  // bit 1 of the current shift value is the next bit on the line
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_txd_nxt   = r_shift[1];
                  w_bit_nxt   = r_bit_idx + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end

`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_baud_tc) begin
               w_baud_nxt  = '0;
               w_txd_nxt   = 1'b1;
               w_bit_nxt   = '0;
               w_state_nxt = ST_STOP;
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end
`endif

         ST_STOP: begin
            // r_bit_idx is reused to count stop-bit periods
            if (w_baud_tc) begin
               w_baud_nxt = '0;
               if (r_bit_idx == STOP_LAST) begin
                  w_bit_nxt     = '0;
                  w_tx_done_nxt = 1'b1;
                  w_state_nxt   = ST_IDLE;
               end else begin
                  w_bit_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end

         default: begin
            w_txd_nxt   = 1'b1;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_fifo_rd_en = r_rd_en;
   assign o_txd        = r_txd;
   assign o_tx_done    = r_tx_done;
   assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx.
// Bytes are pushed into a behavioural FIFO and, in the same step, into an
// expected-byte queue. A line monitor recognises each start bit, pops the
// expected byte, builds the ideal frame waveform from the UART framing rules
// and compares the line cycle by cycle, along with BUSY, TX_DONE and the
// start latency after an idle request.
module tb_fifo_uart_tx;

   localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
   localparam int STOPB = 2;
   localparam int PAR   = 1;
`else
   localparam int STOPB = 1;
   localparam int PAR   = 0;
`endif
   localparam int NB = 9 + PAR + STOPB;
   localparam int L  = NB * CLKS;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_dout = 8'h00;
   logic       rd_en, txd, busy, tx_done;

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(STOPB)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_enable     (enable),
      .i_fifo_empty (fifo_empty),
      .i_fifo_dout  (fifo_dout),
      .o_fifo_rd_en (rd_en),
      .o_txd        (txd),
      .o_busy       (busy),
      .o_tx_done    (tx_done)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural FIFO and scoreboard queue
   logic [7:0] fq[$];
   logic [7:0] exp_q[$];

   always @(posedge clk) begin
      if (rd_en) begin
         chk(fq.size() != 0, "pop_from_empty_fifo", 0, 1);
         if (fq.size() != 0) fifo_dout <= fq.pop_front();
      end
      fifo_empty <= (fq.size() == 0);
   end

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
   endtask

   // Line monitor
   int         cyc = 0;
   bit         in_frame = 0;
   int         pos = 0;
   int         exp_start = -1;
   int         bad_pos = -1;
   int         bad_val = 0;
   int         ctl_err = 0;
   int         frames_done = 0;
   int         rd_cnt = 0;
   bit         prev_rd = 0;
   bit         prev_go = 0;
   bit         ended = 0;
   logic [7:0] cur = 8'h00;
   logic [15:0] wave = 16'hFFFF;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         in_frame  = 0;
         exp_start = -1;
         prev_rd   = 0;
         prev_go   = 0;
      end else begin
         if (rd_en) begin
            rd_cnt++;
            chk(!prev_rd, "rd_en_two_cycles", 1, 0);
            chk(prev_go, "rd_en_without_idle_request", 0, 1);
         end
         ended = 0;
         if (in_frame) begin
            if (pos < L) begin
               if (txd !== wave[pos / CLKS] && bad_pos < 0) begin
                  bad_pos = pos;
                  bad_val = int'(txd);
               end
               if (busy !== 1'b1 || tx_done !== 1'b0) ctl_err++;
               pos++;
            end else begin
               chk(bad_pos < 0, $sformatf("frame_bits_byte_%02h_cycle_%0d", cur, bad_pos),
                   bad_val, (bad_pos < 0) ? bad_val : int'(wave[bad_pos / CLKS]));
               chk(ctl_err == 0, "busy_or_tx_done_during_frame", ctl_err, 0);
               chk(tx_done === 1'b1, "tx_done_after_stop", int'(tx_done), 1);
               chk(busy === 1'b0, "busy_low_in_done_cycle", int'(busy), 0);
               in_frame  = 0;
               exp_start = -1;
               frames_done++;
               ended = 1;
            end
         end
         if (!in_frame) begin
            if (!ended) chk(tx_done === 1'b0, "tx_done_spurious", int'(tx_done), 0);
            if (txd === 1'b0) begin
               chk(exp_start == cyc, "start_bit_latency", cyc, exp_start);
               chk(exp_q.size() != 0, "unexpected_frame", 1, 0);
               if (exp_q.size() != 0) cur = exp_q.pop_front();
               wave = 16'hFFFF;
               wave[0] = 1'b0;
               for (int i = 0; i < 8; i++) wave[1 + i] = cur[i];
`ifdef UART_TX_PARITY_EN
               wave[9] = ^cur;
`endif
               bad_pos  = -1;
               ctl_err  = (busy !== 1'b1) ? 1 : 0;
               in_frame = 1;
               pos      = 1;
            end else if (exp_start >= 0 && cyc >= exp_start) begin
               chk(0, "start_bit_missing", cyc, exp_start);
               exp_start = -1;
            end else if (exp_start < 0 && !busy && enable && !fifo_empty) begin
               // IDLE -> FETCH -> LOAD -> start bit
               exp_start = cyc + 3;
            end
         end
         prev_rd = rd_en;
         prev_go = (!busy && enable && !fifo_empty);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_frames(input int target, input int max_cyc);
      int n = 0;
      while (frames_done < target && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(frames_done >= target, "wait_frames_timeout", frames_done, target);
      tick(1);
   endtask

   task automatic wait_start(input int max_cyc);
      int n = 0;
      while (!in_frame && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(in_frame, "wait_start_timeout", 0, 1);
   endtask

   int base_fr, base_rd;

   initial begin
      // reset state
      tick(3);
      #1;
      chk(txd === 1'b1, "reset_txd", int'(txd), 1);
      chk(rd_en === 1'b0, "reset_rd_en", int'(rd_en), 0);
      chk(busy === 1'b0, "reset_busy", int'(busy), 0);
      chk(tx_done === 1'b0, "reset_tx_done", int'(tx_done), 0);
      tick(1);
      rst = 1'b0;
      enable = 1'b1;
      repeat (100) begin
         @(negedge clk);
         chk({txd, rd_en, busy} === 3'b100, "idle_after_reset", int'({txd, rd_en, busy}), 4);
      end

      // single byte 0xA5
      tick(1);
      base_fr = frames_done;
      base_rd = rd_cnt;
      push(8'hA5);
      wait_frames(base_fr + 1, L + 20);
      chk(rd_cnt - base_rd == 1, "single_byte_rd_pulses", rd_cnt - base_rd, 1);

      // back-to-back frames
      tick(5);
      base_fr = frames_done;
      base_rd = rd_cnt;
      push(8'h00);
      tick(1);
      push(8'hFF);
      tick(1);
      push(8'h3C);
      wait_frames(base_fr + 3, 3 * (L + 10));
      chk(rd_cnt - base_rd == 3, "b2b_rd_pulses", rd_cnt - base_rd, 3);
      chk(busy === 1'b0, "b2b_busy_low_at_end", int'(busy), 0);

      // ENABLE dropped during DATA of frame 1
      tick(5);
      base_fr = frames_done;
      base_rd = rd_cnt;
      push(8'h11);
      tick(1);
      push(8'h22);
      wait_start(20);
      tick(3 * CLKS);
      enable = 1'b0;
      wait_frames(base_fr + 1, L + 20);
      tick(50);
      chk(frames_done - base_fr == 1, "disable_frames_sent", frames_done - base_fr, 1);
      chk(rd_cnt - base_rd == 1, "disable_no_rd_en", rd_cnt - base_rd, 1);
      enable = 1'b1;
      wait_frames(base_fr + 2, L + 20);
      chk(rd_cnt - base_rd == 2, "reenable_rd_pulses", rd_cnt - base_rd, 2);

      // reset during data bit 3 of 0x55
      tick(5);
      enable = 1'b0;
      push(8'h55);
      tick(1);
      push(8'h66);
      tick(3);
      enable = 1'b1;
      wait_start(20);
      tick(4 * CLKS + 1);
      chk(txd === 1'b0, "bit3_of_55_before_reset", int'(txd), 0);
      rst = 1'b1;
      #1;
      chk(txd === 1'b1, "txd_high_on_async_reset", int'(txd), 1);
      chk(busy === 1'b0, "busy_low_on_async_reset", int'(busy), 0);
      tick(3);
      rst = 1'b0;
      base_fr = frames_done;
      base_rd = rd_cnt;
      wait_frames(base_fr + 1, L + 20);
      chk(rd_cnt - base_rd == 1, "after_reset_rd_pulses", rd_cnt - base_rd, 1);
      chk(exp_q.size() == 0, "after_reset_queue_drained", exp_q.size(), 0);

      // parity-relevant bytes
      tick(3);
      base_fr = frames_done;
      push(8'h07);
      tick(1);
      push(8'h03);
      wait_frames(base_fr + 2, 2 * (L + 10));

      // randomized traffic with random ENABLE toggling
      base_fr = frames_done;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 9) == 0) enable = ~enable;
         push(8'($urandom));
         tick($urandom_range(0, 2 * L));
      end
      enable = 1'b1;
      wait_frames(base_fr + 30, 30 * (L + 10));
      chk(exp_q.size() == 0 && fq.size() == 0, "random_drain", exp_q.size() + fq.size(), 0);

      tick(10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
